// File: rtl/piece_queue.sv
// Upcoming-piece FIFO between the piece generator and the game controller, with a
// one-piece preview. Optional reroll-once filter enabled by defining NO_REPEAT_EN.
module piece_queue #(
  parameter int DEPTH   = 4,
  parameter int PIECE_W = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_gen_ready,
  input  logic [PIECE_W-1:0]         i_gen_piece,
  input  logic                       i_flush,
  input  logic                       i_pop,
  output logic                       o_cur_valid,
  output logic [PIECE_W-1:0]         o_cur_piece,
  output logic                       o_next_valid,
  output logic [PIECE_W-1:0]         o_next_piece,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PIECE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_pop_acc;
  logic               w_legal;
  logic               w_space;
  logic               w_accept;
  logic               w_push_acc;
  logic [PTR_W-1:0]   w_rd_nxt;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop_acc  = i_pop & (r_count != '0);
  // gen_piece may be X when gen_ready is low; qualify before comparing
  assign w_legal    = i_gen_ready & (i_gen_ready ? (i_gen_piece != '1) : 1'b0);
  assign w_space    = ~w_full | w_pop_acc;
  assign w_push_acc = w_legal & w_accept & w_space;
  assign w_rd_nxt   = r_rd_ptr + PTR_W'(1);

`ifdef NO_REPEAT_EN
  logic [PIECE_W-1:0] r_last_piece;
  logic               r_last_valid;
  logic               r_rejected;

  assign w_accept = ~(r_last_valid & ~r_rejected & (i_gen_piece == r_last_piece));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_last_piece <= '0;
      r_last_valid <= 1'b0;
      r_rejected   <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_last_piece <= i_gen_piece;
        r_last_valid <= 1'b1;
      end
      // only offers that would otherwise fit influence the reroll flag
      if (w_legal && w_space)
        r_rejected <= ~w_accept;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_mem[r_wr_ptr] <= i_gen_piece;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_acc)
        r_rd_ptr <= w_rd_nxt;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  assign o_cur_valid  = (r_count != '0);
  assign o_next_valid = (r_count >= CNT_W'(2));
  assign o_cur_piece  = o_cur_valid  ? r_mem[r_rd_ptr] : '0;
  assign o_next_piece = o_next_valid ? r_mem[w_rd_nxt] : '0;
  assign o_count      = r_count;
  assign o_full       = w_full;

endmodule

// File: tb/tb_piece_queue.sv
// Directed, table-driven bench for piece_queue (DEPTH=4, PIECE_W=3).
module tb_piece_queue;

  logic       clk;
  logic       reset;
  logic       gen_ready;
  logic [2:0] gen_piece;
  logic       flush;
  logic       pop;
  logic       cur_valid;
  logic [2:0] cur_piece;
  logic       next_valid;
  logic [2:0] next_piece;
  logic [2:0] count;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;

  piece_queue #(.DEPTH(4), .PIECE_W(3)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_gen_ready  (gen_ready),
    .i_gen_piece  (gen_piece),
    .i_flush      (flush),
    .i_pop        (pop),
    .o_cur_valid  (cur_valid),
    .o_cur_piece  (cur_piece),
    .o_next_valid (next_valid),
    .o_next_piece (next_piece),
    .o_count      (count),
    .o_full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       gr;
    logic [2:0] gp;
    logic       pp;
    int         e_count;
    logic       e_cv;
    logic [2:0] e_cp;
    logic       e_nv;
    logic [2:0] e_np;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic gr,
                       input logic [2:0] gp, input logic pp);
    @(negedge clk);
    reset = rst; flush = fl; gen_ready = gr; gen_piece = gp; pop = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ec, input logic ecv,
                           input logic [2:0] ecp, input logic env,
                           input logic [2:0] enp, input logic ef);
    check({tag, " count"},      int'(count),      ec);
    check({tag, " cur_valid"},  int'(cur_valid),  int'(ecv));
    check({tag, " cur_piece"},  int'(cur_piece),  int'(ecp));
    check({tag, " next_valid"}, int'(next_valid), int'(env));
    check({tag, " next_piece"}, int'(next_piece), int'(enp));
    check({tag, " full"},       int'(full),       int'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; gen_ready = 1'b0; gen_piece = '0; pop = 1'b0;

    //          rst fl gr gp    pp  cnt cv cp    nv np    full
    vecs.push_back('{1, 0, 1, 3'd3, 0, 0, 0, 3'd0, 0, 3'd0, 0}); // reset wins
    vecs.push_back('{0, 0, 1, 3'd1, 0, 1, 1, 3'd1, 0, 3'd0, 0});
    vecs.push_back('{0, 0, 1, 3'd2, 0, 2, 1, 3'd1, 1, 3'd2, 0});
    vecs.push_back('{0, 0, 1, 3'd3, 0, 3, 1, 3'd1, 1, 3'd2, 0});
    vecs.push_back('{0, 0, 1, 3'd4, 0, 4, 1, 3'd1, 1, 3'd2, 1});
    vecs.push_back('{0, 0, 1, 3'd5, 0, 4, 1, 3'd1, 1, 3'd2, 1}); // 5 dropped
    vecs.push_back('{0, 0, 1, 3'd6, 1, 4, 1, 3'd2, 1, 3'd3, 1}); // full push+pop
    vecs.push_back('{0, 0, 0, 3'd0, 1, 3, 1, 3'd3, 1, 3'd4, 0});
    vecs.push_back('{0, 0, 0, 3'd0, 1, 2, 1, 3'd4, 1, 3'd6, 0});
    vecs.push_back('{0, 0, 0, 3'd0, 1, 1, 1, 3'd6, 0, 3'd0, 0});
    vecs.push_back('{0, 0, 1, 3'd7, 1, 0, 0, 3'd0, 0, 3'd0, 0}); // 7 dropped
    vecs.push_back('{0, 0, 0, 3'd0, 1, 0, 0, 3'd0, 0, 3'd0, 0}); // pop on empty
    vecs.push_back('{0, 0, 1, 3'd7, 0, 0, 0, 3'd0, 0, 3'd0, 0});
    vecs.push_back('{0, 0, 1, 3'd2, 0, 1, 1, 3'd2, 0, 3'd0, 0});
    vecs.push_back('{0, 0, 1, 3'd5, 0, 2, 1, 3'd2, 1, 3'd5, 0});
    vecs.push_back('{0, 1, 1, 3'd4, 1, 0, 0, 3'd0, 0, 3'd0, 0}); // flush wins
    vecs.push_back('{0, 0, 1, 3'd6, 1, 1, 1, 3'd6, 0, 3'd0, 0}); // empty push+pop
    vecs.push_back('{0, 0, 1, 3'd0, 1, 1, 1, 3'd0, 0, 3'd0, 0});
    vecs.push_back('{0, 0, 0, 3'd0, 1, 0, 0, 3'd0, 0, 3'd0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].gr, vecs[i].gp, vecs[i].pp);
      check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_cv,
                vecs[i].e_cp, vecs[i].e_nv, vecs[i].e_np, vecs[i].e_full);
    end

    // gen_piece is ignored while gen_ready is low
    drive(0, 0, 0, 3'd5, 0);
    check_all("idle_noready", 0, 0, 3'd0, 0, 3'd0, 0);

    // mid-stream reset clears contents
    drive(0, 0, 1, 3'd3, 0);
    drive(0, 0, 1, 3'd1, 0);
    check_all("pre_reset", 2, 1, 3'd3, 1, 3'd1, 0);
    drive(1, 0, 1, 3'd2, 1);
    check_all("mid_reset", 0, 0, 3'd0, 0, 3'd0, 0);

    // repeated offers 4,4,4
    drive(0, 0, 1, 3'd4, 0);
    drive(0, 0, 1, 3'd4, 0);
    drive(0, 0, 1, 3'd4, 0);
    drive(0, 0, 0, 3'd0, 0);
`ifdef NO_REPEAT_EN
    check_all("repeat", 2, 1, 3'd4, 1, 3'd4, 0);
    drive(0, 0, 1, 3'd4, 0); // last=4, not rejected -> dropped again
    check("repeat_again count", int'(count), 2);
`else
    check_all("repeat", 3, 1, 3'd4, 1, 3'd4, 0);
    drive(0, 0, 1, 3'd4, 0);
    check("repeat_again count", int'(count), 4);
`endif

    // wrap-around order: drain and refill across pointer wrap
    drive(0, 1, 0, 3'd0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1, 3'(k), (k >= 2) ? 1'b1 : 1'b0);
    end
    // pushes 0..5, pops at k=2..5 consume 0..3 -> queue 4,5
    check_all("wrap", 2, 1, 3'd4, 1, 3'd5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
